fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 10 +
 rtl/pc_register.sv | 17 +
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble encoding, default reset PC, fetch FSM states
// and the IF/ID pipeline register layout.
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response channel; data returns in the accept cycle.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_register.sv
// Program counter: a redirect load has priority over the +4 step; the sum wraps mod 2^32.
module pc_register #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= target;
    else if (inc)  pc <= pc + 32'd4;
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetches at PC, parks a word accepted during an IF/ID stall, and
// flushes to a redirect target when a branch resolves taken.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCwrite,
  input  logic               IF_IDwrite,
  input  logic               PCSrc,
  input  logic [31:0]        PC_branch,
  fetch_stage_if.master      imem,
  output logic [31:0]        PC_IF_ID,
  output logic [31:0]        INSTRUCTION_IF_ID,
  output logic               valid_IF_ID
);
  import cpu_pkg::*;

  fetch_state_e state;
  if_id_t       if_id;
  logic [31:0]  pc, buffer, target;
  logic         xfer, advance, pc_inc;

  assign target         = word_align(PC_branch);
  assign imem.imem_req  = rst_n && (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign xfer           = imem.imem_req && imem.imem_ready;

  // A real instruction enters IF/ID either straight from memory or from the park buffer
  assign advance = IF_IDwrite && (xfer || state == S_HOLD);
  assign pc_inc  = advance && PCwrite && !PCSrc;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .load   (PCSrc),
    .target (target),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      buffer <= NOP_INSTR;
      if_id  <= {RESET_PC, NOP_INSTR, 1'b0};
    end else if (PCSrc) begin
      if_id  <= {target, NOP_INSTR, 1'b0};
      buffer <= NOP_INSTR;
      state  <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (xfer && IF_IDwrite) begin
            if_id <= {pc, imem.imem_rdata, 1'b1};
          end else if (xfer) begin
            buffer <= imem.imem_rdata;
            state  <= S_HOLD;
          end else if (IF_IDwrite) begin
            if_id <= {pc, NOP_INSTR, 1'b0};
          end
        end
        S_HOLD: begin
          if (IF_IDwrite) begin
            if_id <= {pc, buffer, 1'b1};
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign PC_IF_ID          = if_id.pc;
  assign INSTRUCTION_IF_ID = if_id.instr;
  assign valid_IF_ID       = if_id.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios plus random hazard/ready/branch traffic
// against a queue-based model of the instruction stream.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCwrite, IF_IDwrite, PCSrc, ready;
  logic [31:0] PC_branch, key;
  logic [31:0] PC_IF_ID, INSTRUCTION_IF_ID;
  logic        valid_IF_ID;

  fetch_stage_if bus ();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = bus.imem_addr ^ key;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PCwrite           (PCwrite),
    .IF_IDwrite        (IF_IDwrite),
    .PCSrc             (PCSrc),
    .PC_branch         (PC_branch),
    .imem              (bus.master),
    .PC_IF_ID          (PC_IF_ID),
    .INSTRUCTION_IF_ID (INSTRUCTION_IF_ID),
    .valid_IF_ID       (valid_IF_ID)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: PC, at most one parked word, and the IF/ID contents
  logic [31:0] m_pc;
  logic [31:0] m_park[$];
  logic [64:0] m_id;
  logic        exp_req, obs_req;
  logic [31:0] exp_addr, obs_addr;

  function automatic logic [64:0] dut_id();
    return {PC_IF_ID, INSTRUCTION_IF_ID, valid_IF_ID};
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_park.delete();
    m_id = {RST_PC, NOP, 1'b0};
  endtask

  task automatic drive(input logic pw, input logic iw, input logic rdy);
    PCwrite = pw; IF_IDwrite = iw; ready = rdy; PCSrc = 1'b0;
  endtask

  // One clock: sample request side, advance the model by the rules, clock the DUT.
  task automatic step();
    logic [31:0] word;
    #1;
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    exp_req  = (m_park.size() == 0);
    exp_addr = m_pc;
    word     = m_pc ^ key;
    if (PCSrc) begin
      m_pc = {PC_branch[31:2], 2'b00};
      m_id = {m_pc, NOP, 1'b0};
      m_park.delete();
    end else if (exp_req && ready) begin
      if (IF_IDwrite) begin
        m_id = {m_pc, word, 1'b1};
        if (PCwrite) m_pc = m_pc + 32'd4;
      end else m_park.push_back(word);
    end else if (!exp_req) begin
      if (IF_IDwrite) begin
        m_id = {m_pc, m_park.pop_front(), 1'b1};
        if (PCwrite) m_pc = m_pc + 32'd4;
      end
    end else if (IF_IDwrite) begin
      m_id = {m_pc, NOP, 1'b0};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = '0; PC_branch = '0; drive(1'b1, 1'b1, 1'b1);
    #12;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
    n_vec++; if (dut_id() !== {RST_PC, NOP, 1'b0}) begin n_err++; $display("FAIL reset_ifid got=%h want=%h", dut_id(), {RST_PC, NOP, 1'b0}); end
    @(posedge clk); #3; rst_n = 1'b1; #1;
    model_reset();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_release got=%b/%h want=1/%h", bus.imem_req, bus.imem_addr, RST_PC); end
  endtask

  task automatic test_stream();
    logic [64:0] want[2];
    want[0] = {32'h0, 32'h0, 1'b1};
    want[1] = {32'h4, 32'h4, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1); step();
      n_vec++; if (obs_addr !== 32'(i * 4)) begin n_err++; $display("FAIL stream_addr got=%h want=%h", obs_addr, i * 4); end
      n_vec++; if (dut_id() !== want[i]) begin n_err++; $display("FAIL stream_ifid got=%h want=%h", dut_id(), want[i]); end
      n_vec++; if (dut_id() !== m_id) begin n_err++; $display("FAIL stream_model got=%h want=%h", dut_id(), m_id); end
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b0, 1'b1); step();
    n_vec++; if (obs_addr !== 32'h8 || dut_id() !== {32'h4, 32'h4, 1'b1}) begin n_err++; $display("FAIL lu_park got=%h/%h want=8/%h", obs_addr, dut_id(), {32'h4, 32'h4, 1'b1}); end
    drive(1'b1, 1'b1, 1'b1); step();
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL lu_hold_req got=%b want=0", obs_req); end
    n_vec++; if (dut_id() !== {32'h8, 32'h8, 1'b1}) begin n_err++; $display("FAIL lu_release got=%h want=%h", dut_id(), {32'h8, 32'h8, 1'b1}); end
    step();
    n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'hC) begin n_err++; $display("FAIL lu_next got=%b/%h want=1/c", obs_req, obs_addr); end
    n_vec++; if (dut_id() !== {32'hC, 32'hC, 1'b1}) begin n_err++; $display("FAIL lu_nodup got=%h want=%h", dut_id(), {32'hC, 32'hC, 1'b1}); end
  endtask

  task automatic test_ready_stall();
    key = 32'h5A5A_0000;
    drive(1'b1, 1'b1, 1'b1); PCSrc = 1'b1; PC_branch = 32'h20; step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0); step();
      n_vec++; if (obs_addr !== 32'h20 || dut_id() !== {32'h20, NOP, 1'b0}) begin n_err++; $display("FAIL ready_bubble%0d got=%h/%h want=20/%h", i, obs_addr, dut_id(), {32'h20, NOP, 1'b0}); end
    end
    drive(1'b1, 1'b1, 1'b1); step();
    n_vec++; if (dut_id() !== {32'h20, 32'h20 ^ key, 1'b1}) begin n_err++; $display("FAIL ready_accept got=%h want=%h", dut_id(), {32'h20, 32'h20 ^ key, 1'b1}); end
  endtask

  task automatic test_branch_hold();
    drive(1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 1'b1); PCSrc = 1'b1; PC_branch = 32'h103; step();
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL br_in_hold got=%b want=0", obs_req); end
    n_vec++; if (dut_id() !== {32'h100, NOP, 1'b0}) begin n_err++; $display("FAIL br_flush got=%h want=%h", dut_id(), {32'h100, NOP, 1'b0}); end
    drive(1'b1, 1'b1, 1'b1); step();
    n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin n_err++; $display("FAIL br_refetch got=%b/%h want=1/100", obs_req, obs_addr); end
    n_vec++; if (dut_id() !== {32'h100, 32'h100 ^ key, 1'b1}) begin n_err++; $display("FAIL br_nostale got=%h want=%h", dut_id(), {32'h100, 32'h100 ^ key, 1'b1}); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b1); PCSrc = 1'b1; PC_branch = 32'hFFFF_FFFF; step();
    drive(1'b1, 1'b1, 1'b1); step();
    n_vec++; if (obs_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got=%h want=fffffffc", obs_addr); end
    step();
    n_vec++; if (obs_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got=%h want=0", obs_addr); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b1); step();
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL ar_enter_hold got=%b want=0", bus.imem_req); end
    #2; rst_n = 1'b0; #1;
    n_vec++; if (dut_id() !== {RST_PC, NOP, 1'b0} || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL ar_immediate got=%h/%b want=%h/0", dut_id(), bus.imem_req, {RST_PC, NOP, 1'b0}); end
    #1; rst_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b1, 1'b1); step();
    n_vec++; if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin n_err++; $display("FAIL ar_first got=%b/%h want=1/%h", obs_req, obs_addr, RST_PC); end
    n_vec++; if (dut_id() !== {RST_PC, RST_PC ^ key, 1'b1}) begin n_err++; $display("FAIL ar_nostale got=%h want=%h", dut_id(), {RST_PC, RST_PC ^ key, 1'b1}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) key = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      PCSrc     = 1'($urandom_range(0, 15) == 0);
      PC_branch = $urandom;
      step();
      n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", i, obs_req, exp_req); end
      if (exp_req) begin
        n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i, obs_addr, exp_addr); end
      end
      n_vec++; if (dut_id() !== m_id) begin n_err++; $display("FAIL rnd_ifid cyc=%0d got=%h want=%h", i, dut_id(), m_id); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_ready_stall();
    test_branch_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
